expr_sig_checker: RTL and testbench

- Downstream result consumer for the generated expression blocks.
- Accepts the 90-bit y vector over a valid/ready handshake and folds each accepted vector into a 32-bit MISR signature.
- After a programmed number of vectors, compares the signature against an expected value and reports done/pass.
- Lets regression compare DUT vs golden model with one signature word instead of every vector.

---
 rtl/expr_sig_checker.sv | 102 ++++++++++
 tb/tb_expr_sig_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_sig_checker.sv
// Result-vector signature checker: absorbs y vectors over valid/ready into a MISR
// and compares the final signature against an expected word.
module expr_sig_checker #(
  parameter int unsigned          Y_W   = 90,
  parameter int unsigned          SIG_W = 32,
  parameter int unsigned          CNT_W = 16,
  parameter logic [SIG_W-1:0]     POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]     SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   y,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [SIG_W-1:0] sig,
  output logic             done,
  output logic             pass
);

  localparam int unsigned NCHUNK = (Y_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        num_lat;
  logic [NCHUNK*SIG_W-1:0] y_pad;
  logic [SIG_W-1:0]        fold_v;
  logic [CNT_W-1:0]        vec_nxt;
  logic                    hs;

  function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] s,
                                            input logic [SIG_W-1:0] f);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0)) ^ f;
  endfunction

  // y is zero-padded up to a whole number of chunks before the XOR fold
  always_comb begin
    y_pad            = '0;
    y_pad[Y_W-1:0]   = y;
    fold_v           = '0;
    for (int unsigned i = 0; i < NCHUNK; i++)
      fold_v = fold_v ^ y_pad[i*SIG_W +: SIG_W];
  end

  assign vec_nxt = vec_cnt + CNT_W'(1);
  assign hs      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      vec_cnt  <= '0;
      sig      <= SEED;
      done     <= 1'b0;
      pass     <= 1'b0;
      num_lat  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig      <= SEED;
            vec_cnt  <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            num_lat  <= num_vec;
            if (num_vec == '0) begin
              state    <= CHECK;
              in_ready <= 1'b0;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            vec_cnt <= vec_nxt;
            sig     <= misr(sig, fold_v);
            if (vec_nxt == num_lat) begin
              state    <= CHECK;
              in_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          pass  <= (sig == exp_sig);
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_sig_checker.sv
// Directed bench for expr_sig_checker: single-vector table plus multi-cycle
// sequences for gapped handshakes, async reset mid-run and restart from DONE.
module tb_expr_sig_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [31:0] exp_sig = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [89:0] y = '0;
  logic [15:0] vec_cnt;
  logic [31:0] sig;
  logic        done;
  logic        pass;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  expr_sig_checker #(.Y_W(90), .SIG_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .exp_sig(exp_sig), .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .vec_cnt(vec_cnt), .sig(sig), .done(done), .pass(pass)
  );

  typedef struct {
    logic [15:0] nv;
    logic [89:0] yv;
    logic [31:0] exp_in;
    logic [31:0] sig_exp;
    logic        pass_exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] m_fold(input logic [89:0] v);
    return v[31:0] ^ v[63:32] ^ {6'b0, v[89:64]};
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [31:0] f);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ f;
  endfunction

  function automatic logic [89:0] gen_y(input int k);
    return {26'h2AAAAAA ^ 26'(k * 7), 32'hDEADBEEF + 32'(k), 32'h13579BDF ^ 32'(k << 4)};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_vec_cnt"},  32'(vec_cnt),  32'd0);
    chk({tag, "_sig"},      sig,           32'hFFFFFFFF);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_pass"},     32'(pass),     32'd0);
  endtask

  task automatic run_single(input int idx);
    bit saw_ready = 0;
    bit got_done  = 0;
    @(negedge clk);
    start = 1'b1; num_vec = tbl[idx].nv; exp_sig = tbl[idx].exp_in;
    in_valid = 1'b1; y = tbl[idx].yv;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (in_ready) saw_ready = 1;
      if (done) got_done = 1;
      else @(negedge clk);
    end
    chk($sformatf("t%0d_done", idx), 32'(got_done), 32'd1);
    chk($sformatf("t%0d_sig", idx), sig, tbl[idx].sig_exp);
    chk($sformatf("t%0d_vec_cnt", idx), 32'(vec_cnt), 32'(tbl[idx].nv));
    chk($sformatf("t%0d_pass", idx), 32'(pass), 32'(tbl[idx].pass_exp));
    chk($sformatf("t%0d_in_ready", idx), 32'(in_ready), 32'd0);
    if (tbl[idx].nv == 16'd0)
      chk($sformatf("t%0d_ready_seen", idx), 32'(saw_ready), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] model;
    int          cnt;
    bit          pat [7];
    logic [89:0] ylist [5];

    tbl[0] = '{16'd1, 90'h0, 32'hFB3EE249, 32'hFB3EE249, 1'b1};
    tbl[1] = '{16'd1, 90'h0, 32'h00000000, 32'hFB3EE249, 1'b0};
    tbl[2] = '{16'd1, 90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hF8C11DB6, 32'hF8C11DB6, 1'b1};
    tbl[3] = '{16'd0, 90'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[4] = '{16'd1, 90'h1, 32'h00000000, 32'hFB3EE248, 1'b0};
    tbl[5] = '{16'd1, 90'h3FF_FFFF_0000_0000_0000_0000, 32'hF8C11DB6, 32'hF8C11DB6, 1'b1};
    tbl[6] = '{16'd1, 90'h0000_0001_0000_0001, 32'hFB3EE249, 32'hFB3EE249, 1'b1};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid in IDLE must not be absorbed
    in_valid = 1'b1; y = gen_y(99);
    @(negedge clk);
    @(negedge clk);
    chk("idle_valid_cnt", 32'(vec_cnt), 32'd0);
    chk("idle_valid_sig", sig, 32'hFFFFFFFF);
    in_valid = 1'b0;

    // first-vector timing: done exactly two edges after the handshake
    @(negedge clk);
    start = 1'b1; num_vec = 16'd1; exp_sig = 32'hFB3EE249; in_valid = 1'b1; y = '0;
    @(negedge clk);
    start = 1'b0;
    chk("lat_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("lat_cnt", 32'(vec_cnt), 32'd1);
    chk("lat_ready_low", 32'(in_ready), 32'd0);
    chk("lat_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_pass", 32'(pass), 32'd1);
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_single(i);

    // gapped handshakes, num_vec=4
    @(negedge clk);
    start = 1'b1; num_vec = 16'd4; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("gap_ready", 32'(in_ready), 32'd1);
    model = 32'hFFFFFFFF; cnt = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i]; y = gen_y(i);
      @(negedge clk);
      if (pat[i]) begin
        model = m_misr(model, m_fold(gen_y(i)));
        cnt++;
      end
      chk($sformatf("gap_cnt%0d", i), 32'(vec_cnt), 32'(cnt));
    end
    in_valid = 1'b0;
    exp_sig = model;
    chk("gap_ready_low", 32'(in_ready), 32'd0);
    chk("gap_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_sig", sig, model);
    chk("gap_pass", 32'(pass), 32'd1);

    // async reset after 2 of 5 vectors
    @(negedge clk);
    start = 1'b1; num_vec = 16'd5; in_valid = 1'b1; y = gen_y(40);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    y = gen_y(41);
    @(negedge clk);
    chk("mid_cnt", 32'(vec_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      ylist[i] = gen_y(50 + i);
      model = m_misr(model, m_fold(ylist[i]));
    end
    @(negedge clk);
    start = 1'b1; num_vec = 16'd5; exp_sig = model; in_valid = 1'b1; y = ylist[0];
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      y = ylist[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fresh_cnt", 32'(vec_cnt), 32'd5);
    @(negedge clk);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_sig", sig, model);
    chk("fresh_pass", 32'(pass), 32'd1);

    // restart from DONE, with a start pulse during RUN that must be ignored
    model = m_misr(m_misr(32'hFFFFFFFF, m_fold(gen_y(70))), m_fold(gen_y(71)));
    @(negedge clk);
    start = 1'b1; num_vec = 16'd2; exp_sig = model; in_valid = 1'b1; y = gen_y(70);
    @(negedge clk);
    chk("rs_done_drop", 32'(done), 32'd0);
    chk("rs_seed", sig, 32'hFFFFFFFF);
    chk("rs_cnt0", 32'(vec_cnt), 32'd0);
    chk("rs_ready", 32'(in_ready), 32'd1);
    start = 1'b1; num_vec = 16'd9;
    @(negedge clk);
    start = 1'b0; y = gen_y(71);
    chk("rs_cnt1", 32'(vec_cnt), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_cnt2", 32'(vec_cnt), 32'd2);
    chk("rs_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_sig", sig, model);
    chk("rs_pass", 32'(pass), 32'd1);
    @(negedge clk);
    chk("rs_hold_sig", sig, model);
    chk("rs_hold_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
